// File: rtl/rvfi_pkg.sv
// RVFI trace types shared by the core and trace consumers.
// rvfi_ser_entry_t is the buffer slot used when RVFI_SER_ORDER_EN is defined.
package rvfi_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ORDER_W = 64;

  typedef struct packed {
    logic              valid;
    logic [63:0]       order;
    logic [31:0]       insn;
    logic              trap;
    logic              halt;
    logic              intr;
    logic [1:0]        mode;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [XLEN-1:0]   rs1_rdata;
    logic [XLEN-1:0]   rs2_rdata;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   rd_wdata;
    logic [XLEN-1:0]   pc_rdata;
    logic [XLEN-1:0]   pc_wdata;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_rmask;
    logic [XLEN/8-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_wdata;
  } rvfi_instr_t;

  typedef struct packed {
    rvfi_instr_t        instr;
    logic [ORDER_W-1:0] order;
  } rvfi_ser_entry_t;

endpackage

// File: rtl/rvfi_commit_compactor.sv
// Prefix sum over eligible commit ports: per-port slot offset and total count.
module rvfi_commit_compactor #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned CW              = $clog2(NR_COMMIT_PORTS + 1)
) (
  input  logic [NR_COMMIT_PORTS-1:0]         elig,
  output logic [NR_COMMIT_PORTS-1:0][CW-1:0] offset,
  output logic [CW-1:0]                      count
);

  logic [CW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
      offset[p] = acc;
      acc       = acc + CW'(elig[p]);
    end
    count = acc;
  end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Compacts multi-port RVFI commits into a circular buffer and drains one per cycle.
// Optional feature macro: RVFI_SER_ORDER_EN (64-bit order tag per entry, order_o port).
module rvfi_commit_serializer
  import rvfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]        rvfi_i,
  input  logic                                     flush_i,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  output rvfi_instr_t                              rvfi_o,
  output logic [$clog2(DEPTH):0]                   level_o,
  output logic                                     overflow_o,
  output logic [31:0]                              drop_cnt_o
`ifdef RVFI_SER_ORDER_EN
  ,
  output logic [63:0]                              order_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1);

`ifdef RVFI_SER_ORDER_EN
  typedef rvfi_ser_entry_t slot_t;
`else
  typedef rvfi_instr_t slot_t;
`endif

  logic [NR_COMMIT_PORTS-1:0]         elig;
  logic [NR_COMMIT_PORTS-1:0][CW-1:0] offset;
  logic [CW-1:0]                      k;

  slot_t          mem [DEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [LW-1:0]  level_q;
  logic           valid_q;
  logic           overflow_q;
  logic [31:0]    drop_q;

  logic [NR_COMMIT_PORTS-1:0] do_write;
  logic [LW-1:0]  free, written, dropped, level_d;
  logic           pop;
  logic [32:0]    drop_sum;

  always_comb begin
    for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
      elig[p] = rvfi_i[p].valid | rvfi_i[p].trap;
    end
  end

  rvfi_commit_compactor #(
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
    .CW              (CW)
  ) u_compactor (
    .elig   (elig),
    .offset (offset),
    .count  (k)
  );

  // Free space ignores a same-cycle pop so the write window never aliases the head.
  always_comb begin
    free     = LW'(DEPTH) - level_q;
    written  = '0;
    dropped  = '0;
    do_write = '0;
    pop      = 1'b0;
    if (!flush_i) begin
      written = (LW'(k) < free) ? LW'(k) : free;
      dropped = LW'(k) - written;
      pop     = valid_q & ready_i;
      for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
        do_write[p] = elig[p] & (LW'(offset[p]) < free);
      end
    end
    level_d  = flush_i ? '0 : (level_q + written - LW'(pop));
    drop_sum = {1'b0, drop_q} + 33'(dropped);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      level_q <= level_d;
      valid_q <= (level_d != '0);
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        wptr_q <= wptr_q + PW'(written);
        rptr_q <= rptr_q + PW'(pop);
        if (dropped != '0) begin
          overflow_q <= 1'b1;
          drop_q     <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
      end
    end
  end

`ifdef RVFI_SER_ORDER_EN
  logic [63:0] order_q;

  // Counts every eligible entry, including drops and flushed cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      order_q <= '0;
    end else begin
      order_q <= order_q + 64'(k);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (do_write[p]) begin
        mem[wptr_q + PW'(offset[p])] <= '{instr: rvfi_i[p], order: order_q + 64'(offset[p])};
      end
    end
  end

  assign rvfi_o  = mem[rptr_q].instr;
  assign order_o = valid_q ? mem[rptr_q].order : '0;
`else
  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (do_write[p]) begin
        mem[wptr_q + PW'(offset[p])] <= rvfi_i[p];
      end
    end
  end

  assign rvfi_o = mem[rptr_q];
`endif

  assign valid_o    = valid_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Directed self-checking bench for rvfi_commit_serializer (NR_COMMIT_PORTS=2, DEPTH=16).
module tb_rvfi_commit_serializer;
  import rvfi_pkg::*;

  logic                  clk_i;
  logic                  rst_ni;
  rvfi_instr_t [1:0]     rvfi_i;
  logic                  flush_i;
  logic                  valid_o;
  logic                  ready_i;
  rvfi_instr_t           rvfi_o;
  logic [4:0]            level_o;
  logic                  overflow_o;
  logic [31:0]           drop_cnt_o;
`ifdef RVFI_SER_ORDER_EN
  logic [63:0]           order_o;
`endif

  int checks   = 0;
  int failures = 0;

  rvfi_commit_serializer #(
    .NR_COMMIT_PORTS (2),
    .DEPTH           (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rvfi_i     (rvfi_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .rvfi_o     (rvfi_o),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
`ifdef RVFI_SER_ORDER_EN
    ,
    .order_o    (order_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic v0, input logic t0, input logic [31:0] pc0,
                      input logic v1, input logic t1, input logic [31:0] pc1);
    rvfi_i             = '0;
    rvfi_i[0].valid    = v0;
    rvfi_i[0].trap     = t0;
    rvfi_i[0].pc_rdata = pc0;
    rvfi_i[1].valid    = v1;
    rvfi_i[1].trap     = t1;
    rvfi_i[1].pc_rdata = pc1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    rst_ni  = 1'b0;
    rvfi_i  = '0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    #3;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_level", 64'(level_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
`ifdef RVFI_SER_ORDER_EN
    check("rst_order", order_o, 64'd0);
`endif
    #9 rst_ni = 1'b1;
    tick();

    // Two ports in one cycle, drained in port order
    ready_i = 1'b1;
    push(1, 0, 32'h8000_0000, 1, 0, 32'h8000_0004);
    tick();
    rvfi_i = '0;
    check("t1_valid", 64'(valid_o), 64'd1);
    check("t1_level2", 64'(level_o), 64'd2);
    check("t1_pc0", 64'(rvfi_o.pc_rdata), 64'h8000_0000);
    tick();
    check("t1_level1", 64'(level_o), 64'd1);
    check("t1_pc1", 64'(rvfi_o.pc_rdata), 64'h8000_0004);
    tick();
    check("t1_level0", 64'(level_o), 64'd0);
    check("t1_empty", 64'(valid_o), 64'd0);

    // Trap on port 1 only
    push(0, 0, 32'h0, 0, 1, 32'h100);
    tick();
    rvfi_i = '0;
    check("t2_valid", 64'(valid_o), 64'd1);
    check("t2_level", 64'(level_o), 64'd1);
    check("t2_trap", 64'(rvfi_o.trap), 64'd1);
    check("t2_pc", 64'(rvfi_o.pc_rdata), 64'h100);
    tick();
    check("t2_level0", 64'(level_o), 64'd0);

    // Overflow with consumer stalled
    ready_i = 1'b0;
    for (int c = 0; c < 9; c++) begin
      push(1, 0, 32'h1000 + 32'(8*c), 1, 0, 32'h1004 + 32'(8*c));
      tick();
    end
    rvfi_i = '0;
    check("t3_level", 64'(level_o), 64'd16);
    check("t3_drop", 64'(drop_cnt_o), 64'd2);
    check("t3_ovf", 64'(overflow_o), 64'd1);
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_pc", 64'(rvfi_o.pc_rdata), 64'h1000 + 64'(4*i));
`ifdef RVFI_SER_ORDER_EN
      check("t3_order", order_o, 64'd3 + 64'(i));
`endif
      tick();
    end
    check("t3_drained", 64'(level_o), 64'd0);
    check("t3_ovf_sticky", 64'(overflow_o), 64'd1);

    // Level 15, dual push with simultaneous pop: only port 0 fits
    ready_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      push(1, 0, 32'h4000 + 32'(4*i), 0, 0, 32'h0);
      tick();
    end
    rvfi_i = '0;
    check("t4_level15", 64'(level_o), 64'd15);
    ready_i = 1'b1;
    push(1, 0, 32'h5000, 1, 0, 32'h5004);
    tick();
    rvfi_i = '0;
    check("t4_level_hold", 64'(level_o), 64'd15);
    check("t4_drop", 64'(drop_cnt_o), 64'd3);
    for (int i = 0; i < 15; i++) begin
      exp_pc = (i < 14) ? 32'h4004 + 32'(4*i) : 32'h5000;
      check("t4_pc", 64'(rvfi_o.pc_rdata), 64'(exp_pc));
`ifdef RVFI_SER_ORDER_EN
      check("t4_order", order_o, (i < 14) ? 64'd22 + 64'(i) : 64'd36);
`endif
      tick();
    end
    check("t4_drained", 64'(valid_o), 64'd0);

    // Streaming through pointer wrap
    for (int i = 0; i < 20; i++) begin
      push(1, 0, 32'h2000 + 32'(4*i), 0, 0, 32'h0);
      tick();
      check("t5_pc", 64'(rvfi_o.pc_rdata), 64'h2000 + 64'(4*i));
      check("t5_level", 64'(level_o), 64'd1);
`ifdef RVFI_SER_ORDER_EN
      check("t5_order", order_o, 64'd38 + 64'(i));
`endif
    end
    rvfi_i = '0;
    tick();
    check("t5_empty", 64'(valid_o), 64'd0);

    // Flush with five buffered entries
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1, 0, 32'h6000 + 32'(4*i), 0, 0, 32'h0);
      tick();
    end
    rvfi_i = '0;
    check("t6_level5", 64'(level_o), 64'd5);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("t6_valid", 64'(valid_o), 64'd0);
    check("t6_level", 64'(level_o), 64'd0);
    check("t6_drop", 64'(drop_cnt_o), 64'd3);
    check("t6_ovf", 64'(overflow_o), 64'd1);
    ready_i = 1'b1;
    push(1, 0, 32'h300, 0, 0, 32'h0);
    tick();
    rvfi_i = '0;
    check("t6_post_pc", 64'(rvfi_o.pc_rdata), 64'h300);
    check("t6_post_level", 64'(level_o), 64'd1);
`ifdef RVFI_SER_ORDER_EN
    check("t6_post_order", order_o, 64'd63);
`endif
    tick();

    // Asynchronous reset mid-stream
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(1, 0, 32'h7000 + 32'(4*i), 0, 0, 32'h0);
      tick();
    end
    rvfi_i = '0;
    check("t7_level3", 64'(level_o), 64'd3);
    #2 rst_ni = 1'b0;
    #1;
    check("t7_valid", 64'(valid_o), 64'd0);
    check("t7_level", 64'(level_o), 64'd0);
    check("t7_ovf", 64'(overflow_o), 64'd0);
    check("t7_drop", 64'(drop_cnt_o), 64'd0);
`ifdef RVFI_SER_ORDER_EN
    check("t7_order", order_o, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
